mux41_rr_arbiter: RTL and testbench

Round-robin arbiter and output stage for the 4:1 valid-qualified multiplexer datapath. Four requesters present WIDTH-bit data with a valid flag. The block picks one valid requester per cycle and drives the mux select. It returns a one-hot grant to the chosen requester and registers the selected word with an output valid that honours downstream backpressure. It sits between the four input channels and the consumer of the multiplexed stream.

---
 rtl/mux41_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux41_rr_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mux41_rr_arbiter.sv
// rtl/mux41_rr_arbiter.sv - 4:1 round-robin arbiter with registered output stage
// Optional per-input saturating grant counters when MUX41_ARB_STATS_EN is defined.
module mux41_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             in0_valid,
  input  logic             in1_valid,
  input  logic             in2_valid,
  input  logic             in3_valid,
  input  logic             out_ready,
  output logic [3:0]       grant,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid
`ifdef MUX41_ARB_STATS_EN
  ,
  output logic [6:0]       grant_cnt0,
  output logic [6:0]       grant_cnt1,
  output logic [6:0]       grant_cnt2,
  output logic [6:0]       grant_cnt3
`endif
);

  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       select_q, select_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic [3:0]       req;
  logic             load;
  logic             found;
  logic [1:0]       idx;
  logic [1:0]       win;
  logic [WIDTH-1:0] win_word;

  assign req  = {in3_valid, in2_valid, in1_valid, in0_valid};
  assign load = !valid_q || out_ready;

  // First valid requester at or after ptr, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_word = in0;
    case (win)
      2'd0: win_word = in0;
      2'd1: win_word = in1;
      2'd2: win_word = in2;
      2'd3: win_word = in3;
      default: win_word = in0;
    endcase
  end

  always_comb begin
    grant    = 4'b0000;
    ptr_d    = ptr_q;
    select_d = select_q;
    data_d   = data_q;
    valid_d  = valid_q;
    if (!reset && load) begin
      if (found) begin
        grant[win] = 1'b1;
        ptr_d      = win + 2'd1;
        select_d   = win;
        data_d     = win_word;
        valid_d    = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= 2'd0;
      select_q <= 2'd0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      select_q <= select_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign select    = select_q;
  assign data_out  = data_q;
  assign out_valid = valid_q;

`ifdef MUX41_ARB_STATS_EN
  logic [6:0] cnt_q [4];
  logic [6:0] cnt_d [4];

  // Counters stick at 127 rather than wrapping.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (grant[k] && (cnt_q[k] != 7'd127)) begin
        cnt_d[k] = cnt_q[k] + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        cnt_q[k] <= 7'd0;
      end else begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];
  assign grant_cnt2 = cnt_q[2];
  assign grant_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// tb/tb_mux41_rr_arbiter.sv - vector table plus scoreboard bench for mux41_rr_arbiter
module tb_mux41_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] in0, in1, in2, in3;
  logic       in0_valid, in1_valid, in2_valid, in3_valid;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] select;
  logic [3:0] data_out;
  logic       out_valid;
`ifdef MUX41_ARB_STATS_EN
  logic [6:0] grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3;
`endif

  mux41_rr_arbiter #(.WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .in0_valid(in0_valid),
    .in1_valid(in1_valid),
    .in2_valid(in2_valid),
    .in3_valid(in3_valid),
    .out_ready(out_ready),
    .grant(grant),
    .select(select),
    .data_out(data_out),
    .out_valid(out_valid)
`ifdef MUX41_ARB_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
    .grant_cnt2(grant_cnt2),
    .grant_cnt3(grant_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v;      // {in3_valid..in0_valid}
    logic [15:0] d;      // {in3,in2,in1,in0}
    logic        rdy;
    logic [3:0]  g;      // expected grant before the edge
    logic [3:0]  dout;   // expected registered outputs after the edge
    logic [1:0]  sel;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [3:0] dout;
    logic [1:0] sel;
    logic       ov;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset     = t.rst;
    {in3_valid, in2_valid, in1_valid, in0_valid} = t.v;
    {in3, in2, in1, in0} = t.d;
    out_ready = t.rdy;
  endtask

  initial begin
    exp_t e;
    vec_t t;
    // rst, valids, data, ready, grant, data_out, select, out_valid
    vecs.push_back('{1'b1, 4'b1111, 16'h4321, 1'b1, 4'b0000, 4'h0, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 16'h4321, 1'b1, 4'b0000, 4'h0, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 4'h1, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 16'h4321, 1'b1, 4'b0010, 4'h2, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 16'h4321, 1'b1, 4'b0100, 4'h3, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 16'h4321, 1'b1, 4'b1000, 4'h4, 2'd3, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 4'h1, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0100, 16'h4321, 1'b1, 4'b0100, 4'h3, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b0100, 16'h4321, 1'b1, 4'b0100, 4'h3, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b0101, 16'h4321, 1'b1, 4'b0001, 4'h1, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0101, 16'h4321, 1'b1, 4'b0100, 4'h3, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b0101, 16'h4321, 1'b1, 4'b0001, 4'h1, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 16'h4321, 1'b1, 4'b0000, 4'h1, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0001, 16'h6795, 1'b1, 4'b0001, 4'h5, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 16'h6795, 1'b0, 4'b0000, 4'h5, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 16'h6795, 1'b0, 4'b0000, 4'h5, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 16'h6795, 1'b0, 4'b0000, 4'h5, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 16'h6795, 1'b1, 4'b0010, 4'h9, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 16'h6795, 1'b0, 4'b0000, 4'h9, 2'd1, 1'b1});
    vecs.push_back('{1'b1, 4'b1111, 16'h6795, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 16'h6795, 1'b1, 4'b0001, 4'h5, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 16'h6795, 1'b0, 4'b0000, 4'h5, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b1000, 16'h6795, 1'b1, 4'b1000, 4'h6, 2'd3, 1'b1});
    vecs.push_back('{1'b0, 4'b1000, 16'h6795, 1'b0, 4'b0000, 4'h6, 2'd3, 1'b1});

    t = vecs[0];
    drive(t);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      drive(t);
      e.dout = t.dout;
      e.sel  = t.sel;
      e.ov   = t.ov;
      sb.push_back(e);
      @(negedge clk);
      chk($sformatf("grant[%0d]", i), int'(grant), int'(t.g));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk($sformatf("scoreboard_empty[%0d]", i), 1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("data_out[%0d]", i), int'(data_out), int'(e.dout));
        chk($sformatf("select[%0d]", i), int'(select), int'(e.sel));
        chk($sformatf("out_valid[%0d]", i), int'(out_valid), int'(e.ov));
      end
    end

`ifdef MUX41_ARB_STATS_EN
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    {in3_valid, in2_valid, in1_valid, in0_valid} = 4'b1000;
    out_ready = 1'b1;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      chk("stats_grant", int'(grant), 8);
      @(posedge clk);
      #1;
    end
    chk("grant_cnt3_sat", int'(grant_cnt3), 127);
    chk("grant_cnt0", int'(grant_cnt0), 0);
    chk("grant_cnt1", int'(grant_cnt1), 0);
    chk("grant_cnt2", int'(grant_cnt2), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
